// File: rtl/arbitro_mem_instrucoes_if.sv
// Bus bundle for the instruction-memory arbiter: loader, CPU fetch, debug read,
// memory port and status. The arbiter connects through the slave modport.
interface arbitro_mem_instrucoes_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              load_start;
  logic              load_valid;
  logic [31:0]       load_data;
  logic              load_last;
  logic              load_ready;
  logic              load_err;
  logic [ADDR_W:0]   load_count;

  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_instr;
  logic              cpu_stall;
  logic              cpu_misalign;

  logic              dbg_req;
  logic [31:0]       dbg_addr;
  logic              dbg_gnt;
  logic [31:0]       dbg_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  logic [1:0]        state;

  modport slave (
    input  load_start, load_valid, load_data, load_last,
    input  cpu_addr, dbg_req, dbg_addr, mem_rdata,
    output load_ready, load_err, load_count,
    output cpu_instr, cpu_stall, cpu_misalign,
    output dbg_gnt, dbg_rdata,
    output mem_addr, mem_we, mem_wdata, state
  );

  modport master (
    output load_start, load_valid, load_data, load_last,
    output cpu_addr, dbg_req, dbg_addr, mem_rdata,
    input  load_ready, load_err, load_count,
    input  cpu_instr, cpu_stall, cpu_misalign,
    input  dbg_gnt, dbg_rdata,
    input  mem_addr, mem_we, mem_wdata, state
  );
endinterface

// File: rtl/arbitro_mem_instrucoes.sv
// Instruction-memory controller: serial program load, then CPU fetch sharing the
// read port with a debug reader. Define IMEM_DBG_EN to include the debug port.
module arbitro_mem_instrucoes #(
  parameter int unsigned ADDR_W   = 8,
  parameter bit          BOOT_RUN = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  arbitro_mem_instrucoes_if.slave bus
);
  localparam int unsigned       CNT_W    = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  logic              load_ready;
  logic              mem_we;
  logic              cpu_misalign;
  logic              cpu_own;
  logic              dbg_own;
  logic              dbg_win;
  logic [ADDR_W-1:0] cpu_idx;
  logic [ADDR_W-1:0] mem_addr;
  logic              unused_cpu_hi;

  // Byte address to word index; upper bits wrap modulo the memory depth.
  assign cpu_idx       = bus.cpu_addr[ADDR_W+1:2];
  assign unused_cpu_hi = ^bus.cpu_addr[31:ADDR_W+2];

`ifdef IMEM_DBG_EN
  logic              last_dbg_q;
  logic [ADDR_W-1:0] dbg_idx;
  logic              unused_dbg_hi;

  assign dbg_idx       = bus.dbg_addr[ADDR_W+1:2];
  assign unused_dbg_hi = ^{bus.dbg_addr[31:ADDR_W+2], bus.dbg_addr[1:0]};
  // Debug only wins if the CPU owned the port last RUN cycle, so neither starves.
  assign dbg_win       = bus.dbg_req & ~last_dbg_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_dbg_q <= 1'b0;
    end else if (state_q == ST_RUN) begin
      last_dbg_q <= dbg_win;
    end
  end

  assign mem_addr = dbg_own ? dbg_idx : (cpu_own ? cpu_idx : ptr_q);
`else
  logic unused_dbg;

  assign dbg_win    = 1'b0;
  assign unused_dbg = ^{bus.dbg_req, bus.dbg_addr};
  assign mem_addr   = cpu_own ? cpu_idx : ptr_q;
`endif

  // State and load bookkeeping registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= BOOT_RUN ? ST_RUN : ST_HALT;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next state and port ownership; every strobe stays low while reset is held.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    load_ready   = 1'b0;
    mem_we       = 1'b0;
    cpu_misalign = 1'b0;
    cpu_own      = 1'b0;
    dbg_own      = 1'b0;

    if (reset_n) begin
      case (state_q)
        ST_HALT: begin
          state_d = ST_HALT;
        end
        ST_LOAD: begin
          load_ready = 1'b1;
          if (!bus.load_start && bus.load_valid) begin
            mem_we = 1'b1;
            ptr_d  = ptr_q + ADDR_W'(1);
            cnt_d  = cnt_q + CNT_W'(1);
            if (bus.load_last) begin
              state_d = ST_RUN;
            end else if (ptr_q == PTR_LAST) begin
              err_d   = 1'b1;
              state_d = ST_HALT;
            end
          end
        end
        ST_RUN: begin
          cpu_misalign = |bus.cpu_addr[1:0];
          dbg_own      = dbg_win;
          cpu_own      = ~dbg_win;
        end
        default: begin
          state_d = ST_HALT;
        end
      endcase

      // A load request restarts the loader from any state, dropping any same-cycle word.
      if (bus.load_start) begin
        state_d = ST_LOAD;
        ptr_d   = '0;
        cnt_d   = '0;
        err_d   = 1'b0;
      end
    end
  end

  assign bus.load_ready   = load_ready;
  assign bus.load_err     = err_q;
  assign bus.load_count   = cnt_q;
  assign bus.cpu_instr    = cpu_own ? bus.mem_rdata : 32'h0;
  assign bus.cpu_stall    = ~cpu_own;
  assign bus.cpu_misalign = cpu_misalign;
  assign bus.dbg_gnt      = dbg_own;
  assign bus.dbg_rdata    = dbg_own ? bus.mem_rdata : 32'h0;
  assign bus.mem_addr     = mem_addr;
  assign bus.mem_we       = mem_we;
  assign bus.mem_wdata    = bus.load_data;
  assign bus.state        = state_q;
endmodule

// File: doc/arbitro_mem_instrucoes.md
Name: arbitro_mem_instrucoes

Overview:
Controller and arbiter for the word-addressed instruction memory (combinational read, synchronous write) of the single-cycle MIPS core. It sequences a serial program load into the memory, holding the CPU stalled meanwhile, then releases the CPU to fetch. In RUN it shares the single read port between CPU fetch and a debug read requester.

Parameters:
ADDR_W, 8, word-index width; memory depth DEPTH = 2**ADDR_W words (default 256).
BOOT_RUN, 0, 1 = leave reset in RUN (memory preloaded from file); 0 = leave reset in HALT.

Ports:
clk  input  1  rising-edge clock.
reset_n  input  1  synchronous, active-low reset.
load_start  input  1  pulse: enter LOAD, pointer to word 0.
load_valid  input  1  loader word valid.
load_data  input  32  loader instruction word.
load_last  input  1  qualifies final word of the load.
load_ready  output  1  loader may transfer.
load_err  output  1  sticky overflow flag.
load_count  output  ADDR_W+1  words written by the current/last load.
cpu_addr  input  32  CPU byte PC.
cpu_instr  output  32  fetched instruction.
cpu_stall  output  1  CPU must hold its PC this cycle.
cpu_misalign  output  1  cpu_addr[1:0] != 0 while in RUN.
dbg_req  input  1  debug read request (level, held until grant).
dbg_addr  input  32  debug byte address.
dbg_gnt  output  1  debug read served this cycle.
dbg_rdata  output  32  debug read data, valid when dbg_gnt=1.
mem_addr  output  ADDR_W  memory word index.
mem_we  output  1  memory write enable.
mem_wdata  output  32  memory write data.
mem_rdata  input  32  memory combinational read data.
state  output  2  HALT=0, LOAD=1, RUN=2.

Behaviour:
- Byte-to-word index: addr[ADDR_W+1:2]; upper bits ignored (address wraps modulo DEPTH).
- Reset (reset_n=0 at clk edge): state=HALT (RUN if BOOT_RUN=1), pointer=0, load_count=0, load_err=0, last_owner=CPU. Memory contents untouched. Combinational outputs with reset held: cpu_stall=1, load_ready=0, mem_we=0, dbg_gnt=0, cpu_instr=0, dbg_rdata=0.
- HALT: cpu_stall=1, load_ready=0, mem_we=0, dbg_gnt=0, cpu_instr=0. load_start -> LOAD.
- LOAD: load_ready=1, cpu_stall=1, mem_addr=pointer, mem_wdata=load_data, mem_we=load_valid. Each load_valid handshake writes one word at the edge, pointer+1, load_count+1. On entry via load_start: pointer=0, load_count=0, load_err=0.
  - Handshake with load_last=1 -> RUN next cycle.
  - Handshake at pointer=DEPTH-1 without load_last: word written, load_err=1, -> HALT.
  - load_start while in LOAD: restart (pointer=0, load_count=0); any same-cycle word is not written.
- RUN: load_ready=0, mem_we=0. One read owner per cycle:
  - dbg_req=1 and last_owner=CPU: debug owns; mem_addr=dbg index, dbg_gnt=1, dbg_rdata=mem_rdata, cpu_stall=1, cpu_instr=0; last_owner<=DBG.
  - Otherwise CPU owns; mem_addr=cpu index, cpu_instr=mem_rdata, cpu_stall=0, dbg_gnt=0, dbg_rdata=0; last_owner<=CPU.
  - Continuous dbg_req therefore alternates DBG/CPU; CPU never starves, debug waits at most 1 cycle.
  - load_start -> LOAD (takes priority over arbitration; CPU stalled from the next cycle).
- cpu_misalign combinational, only in RUN; fetch still uses word index (no trap here).
- Zero-latency reads: data is valid in the same cycle as the owning address.

Optional Feature:
IMEM_DBG_EN: when defined, debug port and round-robin arbitration are present as above. When undefined: dbg_gnt=0, dbg_rdata=0, dbg_req/dbg_addr ignored, last_owner removed, CPU owns the port every RUN cycle (cpu_stall=0 in RUN).

Test Plan:
- Reset with BOOT_RUN=0, hold 2 cycles -> state=0, cpu_stall=1, load_ready=0, load_err=0, load_count=0.
- load_start, then 3 words 0x20080005, 0x20090003, 0x01095020 (last on 3rd) -> mem_we on 3 cycles at indices 0, 1, 2; load_count=3; state=2 next cycle; cpu_addr=0x8 -> cpu_instr=0x01095020, cpu_stall=0.
- Load with ADDR_W=2, 4 words, no load_last -> 4 writes, load_err=1, state=0; further load_valid ignored.
- RUN, dbg_req held 4 cycles, dbg_addr=0x4 -> dbg_gnt pattern 1,0,1,0; cpu_stall matches; dbg_rdata=word 1 when granted.
- RUN, cpu_addr=0x402 (ADDR_W=8) -> cpu_misalign=1, mem_addr=0x00 (wrap).
- reset_n=0 mid-LOAD after 2 words -> state=HALT, load_count=0, words 0-1 retained in memory.
